// File: rtl/cdc_src_rr_clear_ctrl.sv
// Source-domain front end for a clearable two-phase CDC: round-robin arbitration
// onto a one-deep output register, plus drain/clear/wait sequencing of clears.
module cdc_src_rr_clear_ctrl #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int CLEAR_TIMEOUT = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          sw_clear_i,
    output logic                          clear_busy_o,
    output logic                          clear_timeout_o,
    output logic [DATA_WIDTH-1:0]         cdc_data_o,
    output logic                          cdc_valid_o,
    input  logic                          cdc_ready_i,
    output logic                          cdc_clear_o,
    input  logic                          cdc_clear_pending_i,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(CLEAR_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DRAIN     = 2'd1,
        ST_CLEAR     = 2'd2,
        ST_WAIT_PEND = 2'd3
    } state_e;

    state_e                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [PTR_W-1:0]        ptr_r;
    logic                    full_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [PTR_W-1:0]        id_r;
    logic                    busy_r;
    logic                    clear_r;
    logic                    timeout_r;

    logic                    found_s;
    logic [PTR_W-1:0]        winner_s;
    logic [PTR_W-1:0]        ptr_next_s;
    logic                    accept_s;
    logic [NUM_REQ-1:0]      ready_s;
    logic [DATA_WIDTH-1:0]   win_data_s;

    // Round-robin search: first valid requester at or after ptr_r, wrapping.
    always_comb begin
        int         idx_v;
        logic [PTR_W-1:0] idx_w;
        found_s  = 1'b0;
        winner_s = '0;
        idx_v    = 0;
        idx_w    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_v = int'(ptr_r) + k;
            if (idx_v >= NUM_REQ) begin
                idx_v = idx_v - NUM_REQ;
            end else begin
                idx_v = idx_v;
            end
            idx_w = idx_v[PTR_W-1:0];
            if (!found_s && req_valid_i[idx_w]) begin
                found_s  = 1'b1;
                winner_s = idx_w;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Accept gating, grant strobe, payload mux and pointer advance.
    always_comb begin
        accept_s   = found_s && (state_r == ST_RUN) && (!full_r || cdc_ready_i)
                     && !cdc_clear_pending_i && !sw_clear_i;
        win_data_s = req_data_i[winner_s*DATA_WIDTH +: DATA_WIDTH];
        if (winner_s == PTR_W'(NUM_REQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = winner_s + PTR_W'(1);
        end
        if (accept_s) begin
            ready_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
        end else begin
            ready_s = '0;
        end
        // The strobe is combinational, so hold it low while reset is applied.
        if (rst_ni) begin
            req_ready_o = ready_s;
        end else begin
            req_ready_o = '0;
        end
    end

    // Output register and clear-sequencing FSM with registered status outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r   <= ST_RUN;
            cnt_r     <= '0;
            ptr_r     <= '0;
            full_r    <= 1'b0;
            data_r    <= '0;
            id_r      <= '0;
            busy_r    <= 1'b0;
            clear_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            if (accept_s) begin
                full_r <= 1'b1;
                data_r <= win_data_s;
                id_r   <= winner_s;
                ptr_r  <= ptr_next_s;
            end else if (full_r && cdc_ready_i) begin
                full_r <= 1'b0;
            end else begin
                full_r <= full_r;
            end

            case (state_r)
                ST_RUN: begin
                    if (sw_clear_i) begin
                        state_r   <= ST_DRAIN;
                        cnt_r     <= '0;
                        timeout_r <= 1'b0;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (!full_r || cdc_ready_i) begin
                        state_r <= ST_CLEAR;
                        clear_r <= 1'b1;
                    end else if (cnt_r == CNT_W'(CLEAR_TIMEOUT)) begin
                        // Stuck downstream: drop the held entry so the clear can go out.
                        full_r    <= 1'b0;
                        timeout_r <= 1'b1;
                        state_r   <= ST_CLEAR;
                        clear_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_CLEAR: begin
                    state_r <= ST_WAIT_PEND;
                    cnt_r   <= '0;
                    clear_r <= 1'b0;
                end
                ST_WAIT_PEND: begin
                    if ((cnt_r != '0) && !cdc_clear_pending_i) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b0;
                    end else if (cnt_r == CNT_W'(CLEAR_TIMEOUT)) begin
                        timeout_r <= 1'b1;
                        state_r   <= ST_RUN;
                        busy_r    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                    busy_r  <= 1'b0;
                    clear_r <= 1'b0;
                end
            endcase
        end
    end

    assign cdc_valid_o     = full_r;
    assign cdc_data_o      = data_r;
    assign grant_id_o      = id_r;
    assign clear_busy_o    = busy_r;
    assign cdc_clear_o     = clear_r;
    assign clear_timeout_o = timeout_r;

endmodule

// File: tb/tb_cdc_src_rr_clear_ctrl.sv
// Directed bench for cdc_src_rr_clear_ctrl (NUM_REQ=4, DATA_WIDTH=32, CLEAR_TIMEOUT=8).
module tb_cdc_src_rr_clear_ctrl;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [3:0]    req_valid_i;
    logic [127:0]  req_data_i;
    logic [3:0]    req_ready_o;
    logic          sw_clear_i;
    logic          clear_busy_o;
    logic          clear_timeout_o;
    logic [31:0]   cdc_data_o;
    logic          cdc_valid_o;
    logic          cdc_ready_i;
    logic          cdc_clear_o;
    logic          cdc_clear_pending_i;
    logic [1:0]    grant_id_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] dv [4];

    cdc_src_rr_clear_ctrl #(
        .NUM_REQ(4), .DATA_WIDTH(32), .CLEAR_TIMEOUT(8)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
        .sw_clear_i(sw_clear_i), .clear_busy_o(clear_busy_o), .clear_timeout_o(clear_timeout_o),
        .cdc_data_o(cdc_data_o), .cdc_valid_o(cdc_valid_o), .cdc_ready_i(cdc_ready_i),
        .cdc_clear_o(cdc_clear_o), .cdc_clear_pending_i(cdc_clear_pending_i),
        .grant_id_o(grant_id_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"},   64'(cdc_valid_o),     64'd0);
        chk({tag, "_clear"},   64'(cdc_clear_o),     64'd0);
        chk({tag, "_busy"},    64'(clear_busy_o),    64'd0);
        chk({tag, "_timeout"}, 64'(clear_timeout_o), 64'd0);
        chk({tag, "_data"},    64'(cdc_data_o),      64'd0);
        chk({tag, "_id"},      64'(grant_id_o),      64'd0);
        chk({tag, "_ready"},   64'(req_ready_o),     64'd0);
    endtask

    initial begin
        logic [3:0] exp_rdy;
        dv[0] = 32'h1111_1111; dv[1] = 32'h2222_2222;
        dv[2] = 32'h3333_3333; dv[3] = 32'h4444_4444;
        req_data_i = {dv[3], dv[2], dv[1], dv[0]};
        rst_ni = 1'b0; req_valid_i = 4'h0; sw_clear_i = 1'b0;
        cdc_ready_i = 1'b0; cdc_clear_pending_i = 1'b0;

        // Reset state
        tick(); #1; chk_idle("rst0");
        tick(); #1; chk_idle("rst1");

        // 1: all requesters valid, sink always ready
        rst_ni = 1'b1; req_valid_i = 4'hF; cdc_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_rdy = 4'b0001 << (k % 4);
            chk("t1_ready", 64'(req_ready_o), 64'(exp_rdy));
            chk("t1_valid", 64'(cdc_valid_o), (k > 0) ? 64'd1 : 64'd0);
            if (k > 0) begin
                chk("t1_id",   64'(grant_id_o), 64'((k - 1) % 4));
                chk("t1_data", 64'(cdc_data_o), 64'(dv[(k - 1) % 4]));
            end
            tick();
        end

        // 2: requester 2 accepted (ptr=2), then sink stalls five cycles
        req_valid_i = 4'b0100; #1;
        chk("t2_acc", 64'(req_ready_o), 64'h4);
        tick();
        cdc_ready_i = 1'b0; req_valid_i = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t2_valid", 64'(cdc_valid_o), 64'd1);
            chk("t2_id",    64'(grant_id_o),  64'd2);
            chk("t2_data",  64'(cdc_data_o),  64'h3333_3333);
            chk("t2_ready", 64'(req_ready_o), 64'd0);
            tick();
        end
        cdc_ready_i = 1'b1; req_valid_i = 4'h0; #1;
        chk("t2_hs_ready", 64'(req_ready_o), 64'd0);
        tick(); #1;
        chk("t2_freed", 64'(cdc_valid_o), 64'd0);

        // 5: external clear pending in RUN blocks accepts; ptr stays at 3
        cdc_clear_pending_i = 1'b1; req_valid_i = 4'hF;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("t5_blocked", 64'(req_ready_o), 64'd0);
            tick();
        end
        cdc_clear_pending_i = 1'b0; #1;
        chk("t5_resume", 64'(req_ready_o), 64'h8);
        tick();
        req_valid_i = 4'h0; #1;
        chk("t5_id",    64'(grant_id_o), 64'd3);
        chk("t5_data",  64'(cdc_data_o), 64'h4444_4444);
        tick(); #1;
        chk("t5_freed", 64'(cdc_valid_o), 64'd0);

        // 3: clear with empty register; sw_clear beats a same-cycle accept
        sw_clear_i = 1'b1; req_valid_i = 4'hF; #1;
        chk("t3_prio", 64'(req_ready_o), 64'd0);
        tick();
        sw_clear_i = 1'b0; req_valid_i = 4'h0; #1;
        chk("t3_busy",  64'(clear_busy_o), 64'd1);
        chk("t3_noclr", 64'(cdc_clear_o),  64'd0);
        tick(); #1;
        chk("t3_clr",   64'(cdc_clear_o), 64'd1);
        chk("t3_clrv",  64'(cdc_valid_o), 64'd0);
        cdc_clear_pending_i = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t3_wait_busy", 64'(clear_busy_o), 64'd1);
            chk("t3_wait_clr",  64'(cdc_clear_o),  64'd0);
            tick();
        end
        cdc_clear_pending_i = 1'b0; #1;
        chk("t3_fall_busy", 64'(clear_busy_o), 64'd1);
        tick(); #1;
        chk("t3_run",  64'(clear_busy_o),    64'd0);
        chk("t3_tout", 64'(clear_timeout_o), 64'd0);

        // 4: register full, sink stuck -> drain timeout after 9 cycles
        req_valid_i = 4'b0001; cdc_ready_i = 1'b0; #1;
        chk("t4_acc", 64'(req_ready_o), 64'h1);
        tick();
        req_valid_i = 4'h0; sw_clear_i = 1'b1;
        tick();
        sw_clear_i = 1'b0;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("t4_drain_valid", 64'(cdc_valid_o), 64'd1);
            chk("t4_drain_clr",   64'(cdc_clear_o), 64'd0);
            tick();
        end
        #1;
        chk("t4_dropped", 64'(cdc_valid_o),     64'd0);
        chk("t4_clr",     64'(cdc_clear_o),     64'd1);
        chk("t4_tout",    64'(clear_timeout_o), 64'd1);
        tick(); #1;
        chk("t4_w0_busy", 64'(clear_busy_o), 64'd1);
        tick(); #1;
        chk("t4_w1_busy", 64'(clear_busy_o), 64'd1);
        tick(); #1;
        chk("t4_run",    64'(clear_busy_o),    64'd0);
        chk("t4_sticky", 64'(clear_timeout_o), 64'd1);

        // New clear clears the sticky flag; then reset mid-WAIT_PEND
        sw_clear_i = 1'b1;
        tick();
        sw_clear_i = 1'b0; #1;
        chk("t6_tout_clr", 64'(clear_timeout_o), 64'd0);
        tick(); tick();
        cdc_clear_pending_i = 1'b1; #1;
        chk("t6_in_wait", 64'(clear_busy_o), 64'd1);
        rst_ni = 1'b0; req_valid_i = 4'hF; cdc_ready_i = 1'b1; #1;
        chk("t6_rdy_gated", 64'(req_ready_o), 64'd0);
        tick(); #1; chk_idle("t6_rst0");
        tick(); #1; chk_idle("t6_rst1");
        rst_ni = 1'b1; cdc_clear_pending_i = 1'b0; #1;
        chk("t6_ptr0", 64'(req_ready_o), 64'h1);
        tick(); #1;
        chk("t6_id",   64'(grant_id_o), 64'd0);
        chk("t6_data", 64'(cdc_data_o), 64'h1111_1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
